riscv_aes_param_regfile: RTL and testbench

RISCV_AES_PARAM_REGFILE -- requirements
Module: riscv_aes_param_regfile

---
 rtl/riscv_aes_pkg.sv | 33 +++
 rtl/riscv_aes_ctrl_fsm.sv | 57 +++++
 rtl/riscv_aes_param_regfile.sv | 110 +++++++++++
 tb/tb_riscv_aes_param_regfile.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_aes_pkg.sv
// Shared types and constants for the AES parameter register file and its control FSM.
package riscv_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } aes_state_e;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_KEY    = 2'd1;
  localparam logic [1:0] SEL_KLEN   = 2'd2;
  localparam logic [1:0] SEL_WBADDR = 2'd3;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2
  } key_len_e;

  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  // Number of key words that are writable for a given key-length code.
  function automatic int unsigned key_words(input logic [1:0] len);
    case (len)
      KEY_192: return 32'd6;
      KEY_256: return 32'd8;
      default: return 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/riscv_aes_ctrl_fsm.sv
// Request/run/done handshake controller; all outputs except capture_c are registered decodes of the next state.
module riscv_aes_ctrl_fsm
  import riscv_aes_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic test_en_i,
  input  logic start_i,
  input  logic eng_ready_i,
  input  logic eng_done_i,
  input  logic result_ack_i,
  output logic eng_start_o,
  output logic result_valid_o,
  output logic busy_o,
  output logic capture_c
);

  aes_state_e r_state;
  aes_state_e w_state_n;

  // Next-state logic; capture_c marks the edge where the engine result is taken.
  always_comb begin
    w_state_n = r_state;
    capture_c = 1'b0;
    if (test_en_i) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i)      w_state_n = ST_REQ;
        ST_REQ:  if (eng_ready_i)  w_state_n = ST_RUN;
        ST_RUN: begin
          if (eng_done_i) begin
            capture_c = 1'b1;
            w_state_n = ST_DONE;
          end
        end
        ST_DONE: if (result_ack_i) w_state_n = ST_IDLE;
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      eng_start_o    <= 1'b0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      eng_start_o    <= (w_state_n == ST_REQ);
      result_valid_o <= (w_state_n == ST_DONE);
      busy_o         <= (w_state_n != ST_IDLE);
    end
  end

endmodule

// File: rtl/riscv_aes_param_regfile.sv
// AES parameter register file: data/key/key-length/writeback-address storage, write checking,
// and result capture around the engine handshake controller.
module riscv_aes_param_regfile
  import riscv_aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_DATA_WORDS = 4,
  parameter int unsigned MAX_KEY_WORDS  = 8,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_KEY_WORDS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               test_en_i,
  input  logic [1:0]                         sel_i,
  input  logic [ADDR_WIDTH-1:0]              waddr_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  input  logic                               wen_i,
  input  logic                               start_i,
  output logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] data_o,
  output logic [MAX_KEY_WORDS*DATA_WIDTH-1:0]  key_o,
  output logic [1:0]                         key_len_o,
  output logic [DATA_WIDTH-1:0]              wb_addr_o,
  output logic                               eng_start_o,
  input  logic                               eng_ready_i,
  input  logic                               eng_done_i,
  input  logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] eng_result_i,
  output logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] result_o,
  output logic                               result_valid_o,
  input  logic                               result_ack_i,
  output logic                               busy_o,
  output logic                               wr_err_o
);

  localparam int unsigned DATA_BITS = NUM_DATA_WORDS * DATA_WIDTH;
  localparam int unsigned KEY_BITS  = MAX_KEY_WORDS * DATA_WIDTH;

  logic [DATA_BITS-1:0]  r_data;
  logic [KEY_BITS-1:0]   r_key;
  logic [1:0]            r_key_len;
  logic [DATA_WIDTH-1:0] r_wb_addr;
  logic [DATA_BITS-1:0]  r_result;
  logic                  r_wr_err;

  logic w_capture_c;
  logic w_bad;
  logic w_wr_req;
  logic w_wr_ok;

  riscv_aes_ctrl_fsm u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .test_en_i      (test_en_i),
    .start_i        (start_i),
    .eng_ready_i    (eng_ready_i),
    .eng_done_i     (eng_done_i),
    .result_ack_i   (result_ack_i),
    .eng_start_o    (eng_start_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .capture_c      (w_capture_c)
  );

  // Per-target legality of the presented write (address range or key-length code).
  always_comb begin
    w_bad = 1'b0;
    case (sel_i)
      SEL_DATA: w_bad = (32'(waddr_i) >= NUM_DATA_WORDS);
      SEL_KEY:  w_bad = (32'(waddr_i) >= key_words(r_key_len));
      SEL_KLEN: w_bad = (wdata_i[1:0] == KEY_LEN_BAD);
      default:  w_bad = 1'b0;
    endcase
  end

  // Test mode swallows writes silently; busy is the registered "state != IDLE".
  assign w_wr_req = wen_i & ~test_en_i;
  assign w_wr_ok  = w_wr_req & ~busy_o & ~w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_key     <= '0;
      r_key_len <= 2'd0;
      r_wb_addr <= '0;
      r_result  <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= w_wr_req & (busy_o | w_bad);
      if (test_en_i) begin
        r_data <= '1;
        r_key  <= '1;
      end else if (w_wr_ok) begin
        case (sel_i)
          SEL_DATA: r_data[32'(waddr_i)*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
          SEL_KEY:  r_key[32'(waddr_i)*DATA_WIDTH +: DATA_WIDTH]  <= wdata_i;
          SEL_KLEN: r_key_len <= wdata_i[1:0];
          default:  r_wb_addr <= wdata_i;
        endcase
      end
      if (w_capture_c) r_result <= eng_result_i;
    end
  end

  assign data_o    = r_data;
  assign key_o     = r_key;
  assign key_len_o = r_key_len;
  assign wb_addr_o = r_wb_addr;
  assign result_o  = r_result;
  assign wr_err_o  = r_wr_err;

endmodule

// File: tb/tb_riscv_aes_param_regfile.sv
// Self-checking bench: write-vector table plus handshake, reset and test-mode sequences,
// with expectations queued at stimulus time and compared after the following clock edge.
module tb_riscv_aes_param_regfile;

  localparam int K_DATA = 0;
  localparam int K_KEY  = 1;
  localparam int K_KLEN = 2;
  localparam int K_WB   = 3;
  localparam int K_ERR  = 4;
  localparam int K_STRT = 5;
  localparam int K_RVAL = 6;
  localparam int K_BUSY = 7;
  localparam int K_RES  = 8;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        err;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         test_en_i;
  logic [1:0]   sel_i;
  logic [2:0]   waddr_i;
  logic [31:0]  wdata_i;
  logic         wen_i;
  logic         start_i;
  logic [127:0] data_o;
  logic [255:0] key_o;
  logic [1:0]   key_len_o;
  logic [31:0]  wb_addr_o;
  logic         eng_start_o;
  logic         eng_ready_i;
  logic         eng_done_i;
  logic [127:0] eng_result_i;
  logic [127:0] result_o;
  logic         result_valid_o;
  logic         result_ack_i;
  logic         busy_o;
  logic         wr_err_o;

  int checks = 0;
  int errors = 0;
  chk_t sb[$];
  vec_t vt[16];

  riscv_aes_param_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .test_en_i      (test_en_i),
    .sel_i          (sel_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .wen_i          (wen_i),
    .start_i        (start_i),
    .data_o         (data_o),
    .key_o          (key_o),
    .key_len_o      (key_len_o),
    .wb_addr_o      (wb_addr_o),
    .eng_start_o    (eng_start_o),
    .eng_ready_i    (eng_ready_i),
    .eng_done_i     (eng_done_i),
    .eng_result_i   (eng_result_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ack_i   (result_ack_i),
    .busy_o         (busy_o),
    .wr_err_o       (wr_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_DATA:  return data_o[idx*32 +: 32];
      K_KEY:   return key_o[idx*32 +: 32];
      K_KLEN:  return {30'd0, key_len_o};
      K_WB:    return wb_addr_o;
      K_ERR:   return {31'd0, wr_err_o};
      K_STRT:  return {31'd0, eng_start_o};
      K_RVAL:  return {31'd0, result_valid_o};
      K_BUSY:  return {31'd0, busy_o};
      default: return result_o[idx*32 +: 32];
    endcase
  endfunction

  task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic check_now();
    chk_t c;
    logic [31:0] got;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      got = observe(c.kind, c.idx);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", c.name, got, c.exp);
      end
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    check_now();
  endtask

  task automatic expect_all_zero(input string tag);
    for (int i = 0; i < 4; i++) expect_val({tag, " data"}, K_DATA, i, 32'h0);
    for (int i = 0; i < 8; i++) expect_val({tag, " key"}, K_KEY, i, 32'h0);
    for (int i = 0; i < 4; i++) expect_val({tag, " result"}, K_RES, i, 32'h0);
    expect_val({tag, " key_len"}, K_KLEN, 0, 32'h0);
    expect_val({tag, " wb_addr"}, K_WB, 0, 32'h0);
    expect_val({tag, " eng_start"}, K_STRT, 0, 32'h0);
    expect_val({tag, " result_valid"}, K_RVAL, 0, 32'h0);
    expect_val({tag, " busy"}, K_BUSY, 0, 32'h0);
    expect_val({tag, " wr_err"}, K_ERR, 0, 32'h0);
  endtask

  initial begin
    vt[0]  = '{2'd0, 3'd0, 32'h00112233, 1'b0, K_DATA, 0, 32'h00112233};
    vt[1]  = '{2'd0, 3'd1, 32'h44556677, 1'b0, K_DATA, 1, 32'h44556677};
    vt[2]  = '{2'd0, 3'd2, 32'h8899AABB, 1'b0, K_DATA, 2, 32'h8899AABB};
    vt[3]  = '{2'd0, 3'd3, 32'hCCDDEEFF, 1'b0, K_DATA, 3, 32'hCCDDEEFF};
    vt[4]  = '{2'd0, 3'd4, 32'h12345678, 1'b1, K_DATA, 0, 32'h00112233};
    vt[5]  = '{2'd1, 3'd5, 32'hCAFEF00D, 1'b1, K_KEY,  5, 32'h00000000};
    vt[6]  = '{2'd1, 3'd3, 32'h11111111, 1'b0, K_KEY,  3, 32'h11111111};
    vt[7]  = '{2'd2, 3'd6, 32'h00000002, 1'b0, K_KLEN, 0, 32'h00000002};
    vt[8]  = '{2'd1, 3'd5, 32'hCAFEF00D, 1'b0, K_KEY,  5, 32'hCAFEF00D};
    vt[9]  = '{2'd1, 3'd7, 32'h77777777, 1'b0, K_KEY,  7, 32'h77777777};
    vt[10] = '{2'd2, 3'd0, 32'hFFFFFFF3, 1'b1, K_KLEN, 0, 32'h00000002};
    vt[11] = '{2'd2, 3'd0, 32'h00000001, 1'b0, K_KLEN, 0, 32'h00000001};
    vt[12] = '{2'd1, 3'd6, 32'h66666666, 1'b1, K_KEY,  6, 32'h00000000};
    vt[13] = '{2'd1, 3'd5, 32'h55555555, 1'b0, K_KEY,  5, 32'h55555555};
    vt[14] = '{2'd3, 3'd7, 32'h80001000, 1'b0, K_WB,   0, 32'h80001000};
    vt[15] = '{2'd2, 3'd0, 32'h00000000, 1'b0, K_KLEN, 0, 32'h00000000};

    rst = 1'b1;
    test_en_i = 1'b0;
    sel_i = 2'd0;
    waddr_i = 3'd0;
    wdata_i = 32'h0;
    wen_i = 1'b0;
    start_i = 1'b0;
    eng_ready_i = 1'b0;
    eng_done_i = 1'b0;
    eng_result_i = '0;
    result_ack_i = 1'b0;

    expect_all_zero("reset");
    tick_check();
    rst = 1'b0;

    // Register write vectors with range and key-length boundaries.
    for (int i = 0; i < 16; i++) begin
      sel_i = vt[i].sel;
      waddr_i = vt[i].addr;
      wdata_i = vt[i].wdata;
      wen_i = 1'b1;
      expect_val($sformatf("vec%0d wr_err", i), K_ERR, 0, {31'd0, vt[i].err});
      expect_val($sformatf("vec%0d reg", i), vt[i].kind, vt[i].idx, vt[i].exp);
      tick_check();
      wen_i = 1'b0;
      expect_val($sformatf("vec%0d wr_err drop", i), K_ERR, 0, 32'h0);
      tick_check();
    end
    expect_val("key7 kept over klen change", K_KEY, 7, 32'h77777777);
    expect_val("key5 kept over klen change", K_KEY, 5, 32'h55555555);
    check_now();

    // Request held while engine not ready, then run, capture and acknowledge.
    start_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_val($sformatf("req wait%0d eng_start", c), K_STRT, 0, 32'h1);
      expect_val($sformatf("req wait%0d busy", c), K_BUSY, 0, 32'h1);
      tick_check();
      start_i = 1'b0;
    end
    eng_ready_i = 1'b1;
    expect_val("run eng_start", K_STRT, 0, 32'h0);
    expect_val("run busy", K_BUSY, 0, 32'h1);
    tick_check();
    eng_ready_i = 1'b0;
    sel_i = 2'd0;
    waddr_i = 3'd0;
    wdata_i = 32'hBADBAD00;
    wen_i = 1'b1;
    start_i = 1'b1;
    expect_val("busy write wr_err", K_ERR, 0, 32'h1);
    expect_val("busy write data0", K_DATA, 0, 32'h00112233);
    tick_check();
    wen_i = 1'b0;
    start_i = 1'b0;
    expect_val("busy write wr_err drop", K_ERR, 0, 32'h0);
    expect_val("start in run ignored", K_STRT, 0, 32'h0);
    tick_check();
    eng_done_i = 1'b1;
    eng_result_i = {4{32'hDEADBEEF}};
    for (int i = 0; i < 4; i++) expect_val("capture result", K_RES, i, 32'hDEADBEEF);
    expect_val("done result_valid", K_RVAL, 0, 32'h1);
    tick_check();
    eng_done_i = 1'b0;
    eng_result_i = {4{32'h01020304}};
    for (int c = 0; c < 2; c++) begin
      expect_val("done hold valid", K_RVAL, 0, 32'h1);
      expect_val("done hold result", K_RES, 1, 32'hDEADBEEF);
      tick_check();
    end
    result_ack_i = 1'b1;
    expect_val("ack result_valid", K_RVAL, 0, 32'h0);
    expect_val("ack busy", K_BUSY, 0, 32'h0);
    expect_val("ack result held", K_RES, 3, 32'hDEADBEEF);
    tick_check();
    result_ack_i = 1'b0;
    eng_done_i = 1'b1;
    expect_val("idle done ignored result", K_RES, 0, 32'hDEADBEEF);
    expect_val("idle done ignored busy", K_BUSY, 0, 32'h0);
    tick_check();
    eng_done_i = 1'b0;

    // Asynchronous reset while running abandons the operation.
    start_i = 1'b1;
    tick_check();
    start_i = 1'b0;
    eng_ready_i = 1'b1;
    expect_val("pre-reset run busy", K_BUSY, 0, 32'h1);
    expect_val("pre-reset run eng_start", K_STRT, 0, 32'h0);
    tick_check();
    eng_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_all_zero("async reset");
    check_now();
    @(negedge clk);
    rst = 1'b0;
    eng_done_i = 1'b1;
    eng_result_i = {4{32'hFFFFFFFF}};
    expect_val("post-reset busy", K_BUSY, 0, 32'h0);
    expect_val("post-reset result_valid", K_RVAL, 0, 32'h0);
    expect_val("post-reset no capture", K_RES, 0, 32'h0);
    tick_check();
    eng_done_i = 1'b0;
    expect_val("post-reset stays idle", K_BUSY, 0, 32'h0);
    tick_check();

    // Same-edge write and start: request sees the new data word.
    sel_i = 2'd0;
    waddr_i = 3'd2;
    wdata_i = 32'hA5A5A5A5;
    wen_i = 1'b1;
    start_i = 1'b1;
    expect_val("same-edge eng_start", K_STRT, 0, 32'h1);
    expect_val("same-edge data2", K_DATA, 2, 32'hA5A5A5A5);
    expect_val("same-edge wr_err", K_ERR, 0, 32'h0);
    tick_check();
    wen_i = 1'b0;
    start_i = 1'b0;

    // Test mode from REQ: forced idle, all-ones storage, silent writes.
    test_en_i = 1'b1;
    waddr_i = 3'd0;
    wdata_i = 32'h0;
    wen_i = 1'b1;
    expect_val("test busy", K_BUSY, 0, 32'h0);
    expect_val("test eng_start", K_STRT, 0, 32'h0);
    expect_val("test wr_err", K_ERR, 0, 32'h0);
    expect_val("test data0", K_DATA, 0, 32'hFFFFFFFF);
    expect_val("test key7", K_KEY, 7, 32'hFFFFFFFF);
    tick_check();
    test_en_i = 1'b0;
    wen_i = 1'b0;
    expect_val("after test data3", K_DATA, 3, 32'hFFFFFFFF);
    expect_val("after test busy", K_BUSY, 0, 32'h0);
    tick_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
